// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-phase instruction sequencer with halt/resume and performance counters
//
// Steps each instruction through FETCH, DECODE (zero or more phases), EXECUTE
// and WRITE_BACK. It also keeps wrapping counts of retired instructions and
// non-halted cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   fetch_ack    in   instruction word returned (only honoured in FETCH)
//   exec_busy    in   execute unit still working (only honoured in EXECUTE)
//   is_branch    in   current instruction is a branch (suppresses write_enable)
//   halt_req     in   current instruction is a halt (only honoured in WRITE_BACK)
//   resume       in   leave HALTED
//   stall        in   freeze phase and suppress strobes
//   phase        out  current phase number, 0 = FETCH, PHASES-1 = WRITE_BACK
//   fetch_req    out  fetch request, high throughout FETCH while running
//   pc_enable    out  PC update strobe in the WRITE_BACK cycle
//   write_enable out  register write strobe in the WRITE_BACK cycle, non-branch only
//   halted       out  sequencer is halted
//   retired      out  completed instruction count (wraps)
//   cycles       out  non-halted cycle count (wraps)

module cpu_sequencer #(
  parameter int PHASES  = 4,
  parameter int PHASE_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_ack,
  input  logic               exec_busy,
  input  logic               is_branch,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               stall,
  output logic [PHASE_W-1:0] phase,
  output logic               fetch_req,
  output logic               pc_enable,
  output logic               write_enable,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [CNT_W-1:0]   cycles
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [PHASE_W-1:0] PH_FETCH = '0;
  localparam logic [PHASE_W-1:0] PH_EXEC  = PHASE_W'(PHASES - 2);
  localparam logic [PHASE_W-1:0] PH_WB    = PHASE_W'(PHASES - 1);
  localparam logic [PHASE_W-1:0] PH_ONE   = PHASE_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic run_active;
  logic wb_fire;

  // Strobes are combinational so that a stall or reset in the WRITE_BACK
  // cycle itself suppresses them, not the cycle after.
  assign run_active   = !reset && (state_q == ST_RUN);
  assign wb_fire      = run_active && (phase_q == PH_WB) && !stall;

  assign fetch_req    = run_active && (phase_q == PH_FETCH);
  assign pc_enable    = wb_fire;
  assign write_enable = wb_fire && !is_branch;
  assign halted       = (state_q == ST_HALTED);
  assign phase        = phase_q;
  assign retired      = retired_q;
  assign cycles       = cycles_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    retired_d = retired_q;
    cycles_d  = cycles_q;

    if (state_q == ST_HALTED) begin
      // Stall has no effect here; only resume matters.
      if (resume) begin
        state_d = ST_RUN;
        phase_d = PH_FETCH;
      end
    end else begin
      cycles_d = cycles_q + CNT_ONE;
      if (!stall) begin
        // WRITE_BACK is tested first, then EXECUTE, then FETCH. With
        // PHASES = 3 this makes phase 1 EXECUTE with no DECODE phase.
        if (phase_q == PH_WB) begin
          phase_d   = PH_FETCH;
          retired_d = retired_q + CNT_ONE;
          if (halt_req) begin
            state_d = ST_HALTED;
          end
        end else if (phase_q == PH_EXEC) begin
          if (!exec_busy) begin
            phase_d = phase_q + PH_ONE;
          end
        end else if (phase_q == PH_FETCH) begin
          if (fetch_ack) begin
            phase_d = phase_q + PH_ONE;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      phase_q   <= PH_FETCH;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PHASES, default 4, phases per instruction; legal range 3..16.
REQ-002 Parameter PHASE_W, default 2, phase encoding width; SHALL be >= clog2(PHASES).
REQ-003 Parameter CNT_W, default 32, width of the performance counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_ack  input  1  instruction memory returns the fetched word this cycle.
REQ-007 exec_busy  input  1  multi-cycle execute unit has not finished.
REQ-008 is_branch  input  1  current instruction is a branch; it suppresses register write.
REQ-009 halt_req  input  1  current instruction is a decoded halt.
REQ-010 resume  input  1  leave the halted state.
REQ-011 stall  input  1  external or debug freeze.
REQ-012 phase  output  PHASE_W  current phase: 0 = FETCH, 1..PHASES-3 = DECODE, PHASES-2 = EXECUTE, PHASES-1 = WRITE_BACK.
REQ-013 fetch_req  output  1  instruction fetch request.
REQ-014 pc_enable  output  1  one-cycle PC update strobe.
REQ-015 write_enable  output  1  one-cycle register-bank write strobe.
REQ-016 halted  output  1  sequencer is halted.
REQ-017 retired  output  CNT_W  count of completed instructions.
REQ-018 cycles  output  CNT_W  count of non-halted clock cycles.

Function
REQ-019 Operating states: RUN, HALTED; phase advances only in RUN.
REQ-020 In RUN, phase SHALL advance by 1 per cycle, subject to REQ-021..REQ-024, and wrap from PHASES-1 to 0.
REQ-021 stall=1: phase held; pc_enable=0; write_enable=0; fetch_req held at its current value; stall has priority over every other input except reset.
REQ-022 FETCH: fetch_req=1 combinationally whenever phase=0, state is RUN and reset=0; phase advances only in a cycle with fetch_ack=1 and stall=0.
REQ-023 fetch_ack outside FETCH, or while HALTED, SHALL be ignored.
REQ-024 EXECUTE: phase advances only when exec_busy=0; exec_busy is ignored in all other phases.
REQ-025 WRITE_BACK always lasts exactly one cycle when not stalled.
REQ-026 In that cycle, pc_enable=1 and write_enable=!is_branch; retired increments by 1.
REQ-027 pc_enable and write_enable SHALL be 0 in every other cycle.
REQ-028 halt_req is sampled only in a non-stalled WRITE_BACK cycle: the halt instruction retires normally, then the next state is HALTED with phase=0.
REQ-029 halt_req in any other phase, or while stalled, SHALL be ignored.
REQ-030 HALTED: halted=1, fetch_req=0, pc_enable=0, write_enable=0; phase holds 0; cycles frozen.
REQ-031 resume=1 while HALTED: next state is RUN, phase=0; FETCH starts the following cycle.
REQ-032 resume while in RUN SHALL be ignored.
REQ-033 stall while HALTED has no effect; resume still wins.
REQ-034 cycles increments by 1 in every RUN cycle, stalled cycles included.
REQ-035 cycles and retired wrap modulo 2^CNT_W with no saturation and no flag.
REQ-036 Phases 1..PHASES-3 advance unconditionally unless stalled; with PHASES=3 there is no DECODE phase and EXECUTE is phase 1.

Reset
REQ-037 reset=1 at a clock edge: state=RUN, phase=0, halted=0, retired=0, cycles=0.
REQ-038 While reset=1: fetch_req=0, pc_enable=0, write_enable=0.
REQ-039 Reset asserted mid-instruction (any phase, stalled or HALTED) SHALL abort the instruction with no strobe, and no retired increment in that cycle.
REQ-040 The first FETCH begins in the cycle after reset deasserts.

Verification
REQ-041 PHASES=4, fetch_ack=1, exec_busy=0 after reset -> phase 0,1,2,3,0; pc_enable=1 only at phase 3; retired=1 after 4 cycles, cycles=4.
REQ-042 fetch_ack low for 3 cycles, then exec_busy high for 2 cycles -> instruction takes 9 cycles; retired=1, cycles=9.
REQ-043 is_branch=1 at WRITE_BACK -> pc_enable=1, write_enable=0; retired still increments.
REQ-044 halt_req=1 at WRITE_BACK -> halted=1 next cycle, cycles frozen for 10 idle cycles; resume pulse -> halted=0, phase=0, fetch_req=1 next cycle.
REQ-045 stall=1 for 2 cycles during WRITE_BACK with halt_req=1 -> no strobes while stalled; pc_enable=1 on the release cycle; halted=1 the cycle after.
REQ-046 PHASES=6 with CNT_W=4, 17 instructions -> phase walks 0..5, retired wraps to 1, cycles wraps correctly; then reset at phase 3 -> all outputs zero next cycle.
